// File: rtl/dspi_stream_checker_if.sv
// DSPI channel bundle: forward data beats from upstream plus the registered backward control path.
interface dspi_stream_checker_if #(
  parameter int unsigned DATA_WIDTH                  = 512,
  parameter int unsigned STREAM_ID_NUM               = 16,
  parameter int unsigned CHUNK_ID_NUM                = 32,
  parameter int unsigned CHANNEL_ID_NUM              = 1024,
  parameter int unsigned STATE_WIDTH                 = 32,
  parameter int unsigned INSTRUCTION_WIDTH           = 2,
  parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16
);
  localparam int unsigned STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM);
  localparam int unsigned CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM);
  localparam int unsigned CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM);

  logic [DATA_WIDTH-1:0]                  in_Data;
  logic [INSTRUCTION_WIDTH-1:0]           in_Type;
  logic                                   in_Last;
  logic [STREAM_ID_WIDTH-1:0]             in_StreamID;
  logic [CHUNK_ID_WIDTH-1:0]              in_ChunkID;
  logic [CHANNEL_ID_WIDTH-1:0]            in_ChannelID;
  logic [STATE_WIDTH-1:0]                 in_State;

  logic [INSTRUCTION_WIDTH-1:0]           out_InstructionType;
  logic [STREAM_ID_WIDTH-1:0]             out_StreamID;
  logic [CHANNEL_ID_WIDTH-1:0]            out_ChannelID;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] out_Parameter;

  // Upstream side: produces beats, consumes instructions.
  modport master (
    output in_Data, in_Type, in_Last, in_StreamID, in_ChunkID, in_ChannelID, in_State,
    input  out_InstructionType, out_StreamID, out_ChannelID, out_Parameter
  );

  // Checker side: consumes beats, produces instructions.
  modport slave (
    input  in_Data, in_Type, in_Last, in_StreamID, in_ChunkID, in_ChannelID, in_State,
    output out_InstructionType, out_StreamID, out_ChannelID, out_Parameter
  );
endinterface

// File: rtl/dspi_stream_checker.sv
// DSPI stream checker: requests N chunks, verifies in-order ChunkIDs and Last flag,
// recovers with REWIND on error/timeout and escalates to RESET once retries run out.
module dspi_stream_checker #(
  parameter int unsigned DATA_WIDTH                  = 512,
  parameter int unsigned STREAM_ID_NUM               = 16,
  parameter int unsigned CHUNK_ID_NUM                = 32,
  parameter int unsigned CHANNEL_ID_NUM              = 1024,
  parameter int unsigned STATE_WIDTH                 = 32,
  parameter int unsigned INSTRUCTION_WIDTH           = 2,
  parameter int unsigned INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_IDLE    = INSTRUCTION_WIDTH'(0),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_REQUEST = INSTRUCTION_WIDTH'(1),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_REWIND  = INSTRUCTION_WIDTH'(2),
  parameter logic [INSTRUCTION_WIDTH-1:0] INSTRUCTION_CMD_RESET   = INSTRUCTION_WIDTH'(3),
  parameter int unsigned TIMEOUT_CYCLES              = 1024,
  parameter int unsigned MAX_RETRIES                 = 3,
  localparam int unsigned STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
  localparam int unsigned CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
  localparam int unsigned CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM),
  localparam int unsigned RETRY_WIDTH      = $clog2(MAX_RETRIES + 2)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [STREAM_ID_WIDTH-1:0]             cfgStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0]            cfgChannelID,
  input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] cfgChunkCount,
  dspi_stream_checker_if.slave                   bus,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   fail,
  output logic [15:0]                            acceptedCount,
  output logic [RETRY_WIDTH-1:0]                 retryCount,
  output logic [15:0]                            discardCount,
  output logic [31:0]                            checksum
);

  localparam int unsigned COUNT_WIDTH = 16;
  localparam int unsigned CSUM_WIDTH  = 32;
  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CMP_WIDTH   = COUNT_WIDTH + INSTRUCTION_PARAMETER_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_REWIND, S_RESYNC, S_RESET, S_DONE
  } state_e;

  state_e                                 state_q,      state_d;
  logic [STREAM_ID_WIDTH-1:0]             stream_q,     stream_d;
  logic [CHANNEL_ID_WIDTH-1:0]            channel_q,    channel_d;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] count_q,      count_d;
  logic [COUNT_WIDTH-1:0]                 accepted_q,   accepted_d;
  logic [RETRY_WIDTH-1:0]                 retry_q,      retry_d;
  logic [COUNT_WIDTH-1:0]                 discard_q,    discard_d;
  logic [CSUM_WIDTH-1:0]                  checksum_q,   checksum_d;
  logic [TIMER_WIDTH-1:0]                 timer_q,      timer_d;
  logic                                   fail_q,       fail_d;
  logic                                   done_q,       done_d;
  logic                                   busy_q,       busy_d;
  logic [INSTRUCTION_WIDTH-1:0]           ins_type_q,   ins_type_d;
  logic [STREAM_ID_WIDTH-1:0]             ins_stream_q, ins_stream_d;
  logic [CHANNEL_ID_WIDTH-1:0]            ins_chan_q,   ins_chan_d;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] ins_param_q,  ins_param_d;

  logic beat_valid_c;
  logic beat_match_c;
  logic chunk_ok_c;
  logic is_final_c;
  logic last_ok_c;
  logic timeout_c;
  logic beat_used_c;
  logic unused_bits_c;

  // Beat classification against the captured stream/channel and the running sequence position.
  assign beat_valid_c = (bus.in_Type != '0);
  assign beat_match_c = beat_valid_c && (bus.in_StreamID == stream_q) && (bus.in_ChannelID == channel_q);
  assign chunk_ok_c   = (bus.in_ChunkID == accepted_q[CHUNK_ID_WIDTH-1:0]);
  assign is_final_c   = ((CMP_WIDTH'(accepted_q) + CMP_WIDTH'(1)) == CMP_WIDTH'(count_q));
  assign last_ok_c    = (bus.in_Last == is_final_c);
  assign timeout_c    = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

  // Payload above the checksum slice and the per-beat state are carried but not inspected.
  assign unused_bits_c = ^{bus.in_State[STATE_WIDTH-1:0], bus.in_Data[DATA_WIDTH-1:CSUM_WIDTH]};

  always_comb begin
    state_d      = state_q;
    stream_d     = stream_q;
    channel_d    = channel_q;
    count_d      = count_q;
    accepted_d   = accepted_q;
    retry_d      = retry_q;
    discard_d    = discard_q;
    checksum_d   = checksum_q;
    timer_d      = timer_q;
    fail_d       = fail_q;
    ins_type_d   = INSTRUCTION_CMD_IDLE;
    ins_stream_d = '0;
    ins_chan_d   = '0;
    ins_param_d  = '0;
    beat_used_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stream_d   = cfgStreamID;
          channel_d  = cfgChannelID;
          count_d    = cfgChunkCount;
          accepted_d = '0;
          retry_d    = '0;
          checksum_d = '0;
          fail_d     = 1'b0;
          if (cfgChunkCount == '0) begin
            state_d = S_DONE;
          end else begin
            // REQUEST is registered on the start edge so it is visible in the ISSUE cycle.
            state_d      = S_ISSUE;
            ins_type_d   = INSTRUCTION_CMD_REQUEST;
            ins_stream_d = cfgStreamID;
            ins_chan_d   = cfgChannelID;
            ins_param_d  = cfgChunkCount;
          end
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT, S_RESYNC: begin
        // In RESYNC only the expected chunk is processed; other matching beats are stale.
        if (beat_match_c && ((state_q == S_WAIT) || chunk_ok_c)) begin
          beat_used_c = 1'b1;
          timer_d     = '0;
          if (chunk_ok_c && last_ok_c) begin
            accepted_d = COUNT_WIDTH'(accepted_q + COUNT_WIDTH'(1));
            checksum_d = checksum_q ^ bus.in_Data[CSUM_WIDTH-1:0];
            state_d    = is_final_c ? S_DONE : S_WAIT;
          end else begin
            state_d = S_REWIND;
          end
        end else if (timeout_c) begin
          state_d = S_REWIND;
        end else begin
          timer_d = TIMER_WIDTH'(timer_q + TIMER_WIDTH'(1));
        end
      end

      S_REWIND: begin
        if (retry_q == RETRY_WIDTH'(MAX_RETRIES)) begin
          state_d = S_RESET;
        end else begin
          ins_type_d   = INSTRUCTION_CMD_REWIND;
          ins_stream_d = stream_q;
          ins_chan_d   = channel_q;
          ins_param_d  = INSTRUCTION_PARAMETER_WIDTH'(accepted_q);
          retry_d      = RETRY_WIDTH'(retry_q + RETRY_WIDTH'(1));
          timer_d      = '0;
          state_d      = S_RESYNC;
        end
      end

      S_RESET: begin
        ins_type_d   = INSTRUCTION_CMD_RESET;
        ins_stream_d = stream_q;
        ins_chan_d   = channel_q;
        fail_d       = 1'b1;
        state_d      = S_IDLE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any valid beat that is neither consumed nor flagged as an error is discarded.
    if (beat_valid_c && !beat_used_c && (discard_q != '1)) begin
      discard_d = COUNT_WIDTH'(discard_q + COUNT_WIDTH'(1));
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      stream_q     <= '0;
      channel_q    <= '0;
      count_q      <= '0;
      accepted_q   <= '0;
      retry_q      <= '0;
      discard_q    <= '0;
      checksum_q   <= '0;
      timer_q      <= '0;
      fail_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ins_type_q   <= INSTRUCTION_CMD_IDLE;
      ins_stream_q <= '0;
      ins_chan_q   <= '0;
      ins_param_q  <= '0;
    end else begin
      state_q      <= state_d;
      stream_q     <= stream_d;
      channel_q    <= channel_d;
      count_q      <= count_d;
      accepted_q   <= accepted_d;
      retry_q      <= retry_d;
      discard_q    <= discard_d;
      checksum_q   <= checksum_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ins_type_q   <= ins_type_d;
      ins_stream_q <= ins_stream_d;
      ins_chan_q   <= ins_chan_d;
      ins_param_q  <= ins_param_d;
    end
  end

  assign bus.out_InstructionType = ins_type_q;
  assign bus.out_StreamID        = ins_stream_q;
  assign bus.out_ChannelID       = ins_chan_q;
  assign bus.out_Parameter       = ins_param_q;

  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign acceptedCount = accepted_q;
  assign retryCount    = retry_q;
  assign discardCount  = discard_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_dspi_stream_checker.sv
// Scoreboard bench for dspi_stream_checker: directed beat sequences, expected instructions and
// completions queued at stimulus time and checked by an independent output monitor.
module tb_dspi_stream_checker;

  localparam int unsigned TIMEOUT = 1024;

  typedef struct packed {
    logic [1:0]   typ;
    logic         last;
    logic [3:0]   stream;
    logic [4:0]   chunk;
    logic [9:0]   channel;
    logic [31:0]  state;
    logic [511:0] data;
  } beat_t;

  // kind: 1 REQUEST, 2 REWIND, 3 RESET, 4 done pulse
  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] param;
    logic [3:0]  stream;
    logic [9:0]  channel;
    logic [15:0] acc;
    logic [2:0]  retry;
    logic [31:0] csum;
    logic        fail;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [3:0]  cfgStreamID;
  logic [9:0]  cfgChannelID;
  logic [15:0] cfgChunkCount;
  logic        busy, done, fail;
  logic [15:0] acceptedCount;
  logic [2:0]  retryCount;
  logic [15:0] discardCount;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;
  int exp_disc = 0;
  exp_t expq[$];
  exp_t mon_e;
  logic [2:0] mon_k;

  beat_t src = '0;
  beat_t dly [100];
  beat_t cur;
  logic  use_dly = 1'b0;

  dspi_stream_checker_if bus ();

  dspi_stream_checker dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfgStreamID   (cfgStreamID),
    .cfgChannelID  (cfgChannelID),
    .cfgChunkCount (cfgChunkCount),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .acceptedCount (acceptedCount),
    .retryCount    (retryCount),
    .discardCount  (discardCount),
    .checksum      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 100-stage artificial pipeline delay between the beat source and the checker.
  always @(posedge clk) begin
    dly[0] <= src;
    for (int k = 1; k < 100; k++) dly[k] <= dly[k-1];
  end

  assign cur              = use_dly ? dly[99] : src;
  assign bus.in_Data      = cur.data;
  assign bus.in_Type      = cur.typ;
  assign bus.in_Last      = cur.last;
  assign bus.in_StreamID  = cur.stream;
  assign bus.in_ChunkID   = cur.chunk;
  assign bus.in_ChannelID = cur.channel;
  assign bus.in_State     = cur.state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dval(input int i, input logic [31:0] seed);
    return seed ^ (32'(i) * 32'h9E37_79B9) ^ 32'(i);
  endfunction

  function automatic logic [31:0] xsum(input int n, input logic [31:0] seed);
    logic [31:0] x = '0;
    for (int i = 0; i < n; i++) x ^= dval(i, seed);
    return x;
  endfunction

  task automatic push_instr(input logic [2:0] k, input logic [15:0] p, input logic [3:0] s, input logic [9:0] c);
    exp_t e = '0;
    e.kind = k; e.param = p; e.stream = s; e.channel = c;
    expq.push_back(e);
  endtask

  task automatic push_reset(input logic [3:0] s, input logic [9:0] c, input logic [2:0] r);
    exp_t e = '0;
    e.kind = 3'd3; e.stream = s; e.channel = c; e.retry = r; e.fail = 1'b1;
    expq.push_back(e);
  endtask

  task automatic push_done(input logic [15:0] a, input logic [2:0] r, input logic [31:0] cs);
    exp_t e = '0;
    e.kind = 3'd4; e.acc = a; e.retry = r; e.csum = cs;
    expq.push_back(e);
  endtask

  task automatic do_start(input logic [3:0] s, input logic [9:0] c, input logic [15:0] n);
    cfgStreamID = s; cfgChannelID = c; cfgChunkCount = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] t, input logic [3:0] s, input logic [9:0] c,
                      input int ch, input logic last, input logic [31:0] d);
    src.typ = t; src.stream = s; src.channel = c; src.chunk = 5'(ch);
    src.last = last; src.data = 512'(d); src.state = 32'(ch);
    tick();
    src = '0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  // Output monitor: every instruction issue or done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rstn && (bus.out_InstructionType != 2'd0 || done)) begin
      mon_k = done ? 3'd4 : {1'b0, bus.out_InstructionType};
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual_kind=%0d required=none", mon_k);
      end else begin
        mon_e = expq.pop_front();
        chk("out_kind", 64'(mon_k), 64'(mon_e.kind));
        if (mon_e.kind == 3'd4) begin
          chk("done_accepted", 64'(acceptedCount), 64'(mon_e.acc));
          chk("done_retry", 64'(retryCount), 64'(mon_e.retry));
          chk("done_checksum", 64'(checksum), 64'(mon_e.csum));
        end else begin
          chk("ins_param", 64'(bus.out_Parameter), 64'(mon_e.param));
          chk("ins_stream", 64'(bus.out_StreamID), 64'(mon_e.stream));
          chk("ins_channel", 64'(bus.out_ChannelID), 64'(mon_e.channel));
          if (mon_e.kind == 3'd3) begin
            chk("reset_fail", 64'(fail), 64'(mon_e.fail));
            chk("reset_retry", 64'(retryCount), 64'(mon_e.retry));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0;
    cfgStreamID = '0; cfgChannelID = '0; cfgChunkCount = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_type", 64'(bus.out_InstructionType), 64'd0);
    chk("rst_param", 64'(bus.out_Parameter), 64'd0);
    chk("rst_accepted", 64'(acceptedCount), 64'd0);
    chk("rst_discard", 64'(discardCount), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rstn = 1'b1;
    repeat (2) tick();

    // Basic transfer N=4
    push_instr(3'd1, 16'd4, 4'd3, 10'd7);
    push_done(16'd4, 3'd0, xsum(4, 32'h1111_0001));
    do_start(4'd3, 10'd7, 16'd4);
    tick();
    for (int i = 0; i < 4; i++) send(2'd1, 4'd3, 10'd7, i, i == 3, dval(i, 32'h1111_0001));
    wait_idle(20, "t1_idle");

    // N=40 through the 100-stage delay; ChunkIDs wrap 31->0
    repeat (110) tick();
    use_dly = 1'b1;
    push_instr(3'd1, 16'd40, 4'd3, 10'd7);
    push_done(16'd40, 3'd0, xsum(40, 32'h2222_0002));
    do_start(4'd3, 10'd7, 16'd40);
    for (int i = 0; i < 40; i++) send(2'd1, 4'd3, 10'd7, i % 32, i == 39, dval(i, 32'h2222_0002));
    wait_idle(300, "t2_idle");
    chk("t2_discard", 64'(discardCount), 64'(exp_disc));
    repeat (110) tick();
    use_dly = 1'b0;

    // Sequence gap 0,1,3 -> REWIND 2, stale beats discarded, resend completes
    push_instr(3'd1, 16'd6, 4'd3, 10'd7);
    push_instr(3'd2, 16'd2, 4'd3, 10'd7);
    push_done(16'd6, 3'd1, xsum(6, 32'h3333_0003));
    do_start(4'd3, 10'd7, 16'd6);
    tick();
    send(2'd1, 4'd3, 10'd7, 0, 1'b0, dval(0, 32'h3333_0003));
    send(2'd1, 4'd3, 10'd7, 1, 1'b0, dval(1, 32'h3333_0003));
    send(2'd1, 4'd3, 10'd7, 3, 1'b0, dval(3, 32'h3333_0003));
    tick();
    send(2'd1, 4'd3, 10'd7, 4, 1'b0, 32'hDEAD_0004);
    send(2'd1, 4'd3, 10'd7, 5, 1'b1, 32'hDEAD_0005);
    exp_disc += 2;
    for (int i = 2; i < 6; i++) send(2'd1, 4'd3, 10'd7, i, i == 5, dval(i, 32'h3333_0003));
    wait_idle(20, "t3_idle");
    chk("t3_discard", 64'(discardCount), 64'(exp_disc));

    // Early Last flag is an error -> REWIND 1, then clean completion
    push_instr(3'd1, 16'd3, 4'd2, 10'd12);
    push_instr(3'd2, 16'd1, 4'd2, 10'd12);
    push_done(16'd3, 3'd1, xsum(3, 32'h4444_0004));
    do_start(4'd2, 10'd12, 16'd3);
    tick();
    send(2'd1, 4'd2, 10'd12, 0, 1'b0, dval(0, 32'h4444_0004));
    send(2'd1, 4'd2, 10'd12, 1, 1'b1, dval(1, 32'h4444_0004));
    repeat (2) tick();
    send(2'd1, 4'd2, 10'd12, 1, 1'b0, dval(1, 32'h4444_0004));
    send(2'd1, 4'd2, 10'd12, 2, 1'b1, dval(2, 32'h4444_0004));
    wait_idle(20, "t3b_idle");

    // No beats: timeouts, three REWINDs, then RESET
    push_instr(3'd1, 16'd2, 4'd5, 10'd9);
    for (int i = 0; i < 3; i++) push_instr(3'd2, 16'd0, 4'd5, 10'd9);
    push_reset(4'd5, 10'd9, 3'd3);
    do_start(4'd5, 10'd9, 16'd2);
    n = 0;
    while (bus.out_InstructionType != 2'd2 && n < 2000) begin
      tick();
      n++;
    end
    chk("t4_timeout_window", 64'((n >= TIMEOUT) && (n <= TIMEOUT + 3)), 64'd1);
    wait_idle(5000, "t4_idle");
    chk("t4_fail", 64'(fail), 64'd1);
    chk("t4_retry", 64'(retryCount), 64'd3);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_accepted", 64'(acceptedCount), 64'd0);

    // Foreign stream 4 interleaved with stream 3
    push_instr(3'd1, 16'd4, 4'd3, 10'd7);
    push_done(16'd4, 3'd0, xsum(4, 32'h5555_0005));
    do_start(4'd3, 10'd7, 16'd4);
    tick();
    chk("t5_fail_cleared", 64'(fail), 64'd0);
    send(2'd1, 4'd3, 10'd7, 0, 1'b0, dval(0, 32'h5555_0005));
    send(2'd3, 4'd4, 10'd7, 0, 1'b0, 32'hBAD0_0000);
    send(2'd1, 4'd3, 10'd7, 1, 1'b0, dval(1, 32'h5555_0005));
    send(2'd3, 4'd4, 10'd7, 1, 1'b0, 32'hBAD0_0001);
    send(2'd1, 4'd3, 10'd7, 2, 1'b0, dval(2, 32'h5555_0005));
    send(2'd2, 4'd4, 10'd7, 5, 1'b1, 32'hBAD0_0005);
    send(2'd1, 4'd3, 10'd7, 3, 1'b1, dval(3, 32'h5555_0005));
    exp_disc += 3;
    wait_idle(20, "t5_idle");
    chk("t5_discard", 64'(discardCount), 64'(exp_disc));

    // Zero-length transfer completes without any instruction
    push_done(16'd0, 3'd0, 32'd0);
    do_start(4'd1, 10'd1, 16'd0);
    wait_idle(10, "t7_idle");

    // Asynchronous reset mid-WAIT, then a fresh transfer
    push_instr(3'd1, 16'd4, 4'd3, 10'd7);
    do_start(4'd3, 10'd7, 16'd4);
    tick();
    send(2'd1, 4'd3, 10'd7, 0, 1'b0, dval(0, 32'h6666_0006));
    send(2'd1, 4'd3, 10'd7, 1, 1'b0, dval(1, 32'h6666_0006));
    rstn = 1'b0;
    #2;
    exp_disc = 0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_type", 64'(bus.out_InstructionType), 64'd0);
    chk("t6_accepted", 64'(acceptedCount), 64'd0);
    chk("t6_checksum", 64'(checksum), 64'd0);
    chk("t6_discard", 64'(discardCount), 64'(exp_disc));
    chk("t6_retry", 64'(retryCount), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    push_instr(3'd1, 16'd1, 4'd3, 10'd7);
    push_done(16'd1, 3'd0, dval(0, 32'h6666_0006));
    do_start(4'd3, 10'd7, 16'd1);
    tick();
    send(2'd1, 4'd3, 10'd7, 0, 1'b1, dval(0, 32'h6666_0006));
    wait_idle(20, "t6_idle");

    repeat (5) tick();
    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
